channel_emulator: RTL and testbench
===================================

// Module: channel_emulator
// PURPOSE
//  Multi-lane, cycle-based behavioural channel model for RX bring-up. Per lane it
//  converts a serial bit stream into an unsigned WIDTH-bit analog-level code.
//  Response modes: bypass, saturating slew, first-order IIR (RC) and hold.
//  Optional LFSR noise, plus a hysteresis slicer that recovers bits for the CDR.
// PARAMETERS
//  LANES       4          number of independent lanes
//  WIDTH       8          level code width; MAX = 2**WIDTH-1
//  SLEW_STEP   1          per-update increment/decrement in SLEW mode (1..MAX)
//  ALPHA_SHIFT 3          IIR coefficient = 2**-ALPHA_SHIFT (1..WIDTH-1)
//  THRESHOLD   2**(WIDTH-1)  slicer centre
//  HYST        8          slicer half-window (THRESHOLD+-HYST, clamped to 0..MAX)
//  NOISE_EN    0          1 = add LFSR noise to out_level
//  NOISE_BITS  2          noise word width; LANES*NOISE_BITS <= 16
//  LFSR_SEED   16'hACE1   LFSR reset value; must be non-zero
// PORTS
//  clk        in   1            model clock
//  rst        in   1            synchronous, active-high reset
//  en         in   1            update strobe; model advances only when 1
//  mode       in   2            0 BYPASS, 1 SLEW, 2 IIR, 3 HOLD (shared by all lanes)
//  in         in   LANES        serial input bit per lane
//  out_level  out  LANES*WIDTH  level code; lane k at [k*WIDTH +: WIDTH]
//  out_bit    out  LANES        sliced bit per lane
//  out_valid  out  1            high for exactly the cycle after an en update
// BEHAVIOUR
//  - Reset (rst=1 at posedge clk, dominates en): level=0, out_level=0, out_bit=0,
//    out_valid=0, lfsr=LFSR_SEED. Reset mid-operation discards all state.
//  - en=0: level, out_level, out_bit and lfsr hold; out_valid=0 on next edge.
//  - en=1: per lane target = in[k] ? MAX : 0; level updated by mode:
//    BYPASS: level <= target.
//    SLEW:   in=1: level <= min(level+SLEW_STEP, MAX); in=0: max(level-SLEW_STEP, 0).
//            Computed in WIDTH+1 bits; no wrap-around.
//    IIR:    diff = target-level (signed, WIDTH+1 bits); d = diff >>> ALPHA_SHIFT;
//            if d==0 and diff!=0 then d = sign(diff) (guarantees exact convergence);
//            level <= level+d. Never overshoots target.
//    HOLD:   level unchanged; lfsr still advances.
//  - Mode changes take effect at the next en edge; level is preserved across changes.
//  - Latency: in/mode sampled at en edge E; out_level, out_bit and out_valid=1
//    are visible after E (one clock). No back-pressure.
//  - Noise: lfsr = 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advanced on every en.
//    Lane k offset n = signed lfsr[k*NOISE_BITS +: NOISE_BITS] (taken from the
//    pre-advance value).
//    out_level = sat(level+n, 0, MAX) when NOISE_EN, else out_level = level.
//    Noise never feeds back into level.
//  - Slicer: computed from the new out_level, registered on the same edge.
//    1 if out_level >= THRESHOLD+HYST; 0 if out_level < THRESHOLD-HYST; else hold.
//  - Simultaneous in change and mode change at one edge: new mode uses the new in.
// TESTING
//  1. rst, mode=SLEW, in=1, en=1 x300 -> out_level 1,2,...,255 then stays 255;
//     out_bit rises on the update where level=136.
//  2. Continue from 1: in=0 -> out_level 254 down to 0, stops at 0 with no wrap;
//     out_bit falls at level=119.
//  3. mode=BYPASS, in toggles 1,0,1 each en -> out_level 255,0,255, out_bit 1,0,1,
//     out_valid=1 each following cycle.
//  4. rst, mode=IIR, in=1 -> out_level 31,59,83,...; reaches 255 exactly and holds;
//     then in=0 reaches exactly 0.
//  5. en pulsed every 3rd cycle and mode=HOLD at level 200 -> values frozen;
//     out_valid=1 only after en edges.
//  6. NOISE_EN=1: run 50 updates, assert rst mid-stream at level 200, rerun ->
//     all outputs 0 the cycle after rst, and noise sequence repeats bit-exact;
//     out_level stays within 0..255.

Source files
------------

// File: rtl/channel_emulator.sv
// Multi-lane behavioural channel model. Each lane turns a serial bit into a WIDTH-bit
// analog-level code using a bypass, slew, IIR or hold response, with optional noise and a slicer.
module channel_emulator #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SLEW_STEP   = 1,
  parameter int unsigned ALPHA_SHIFT = 3,
  parameter int unsigned THRESHOLD   = 2**(WIDTH-1),
  parameter int unsigned HYST        = 8,
  parameter bit          NOISE_EN    = 1'b0,
  parameter int unsigned NOISE_BITS  = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [LANES-1:0]       in,
  output logic [LANES*WIDTH-1:0] out_level,
  output logic [LANES-1:0]       out_bit,
  output logic                   out_valid
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_SLEW   = 2'd1,
    MODE_IIR    = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam int unsigned      MAX       = (2**WIDTH) - 1;
  localparam logic [WIDTH-1:0] MAX_LVL   = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   SLEW_EXT  = (WIDTH+1)'(SLEW_STEP);
  localparam int unsigned      HI_INT    = (THRESHOLD + HYST > MAX) ? MAX : THRESHOLD + HYST;
  localparam int unsigned      LO_INT    = (HYST > THRESHOLD) ? 0 : THRESHOLD - HYST;
  localparam logic [WIDTH-1:0] SLICE_HI  = WIDTH'(HI_INT);
  localparam logic [WIDTH-1:0] SLICE_LO  = WIDTH'(LO_INT);
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;

  logic [WIDTH-1:0]       level_q [LANES];
  logic [WIDTH-1:0]       level_d [LANES];
  logic [LANES*WIDTH-1:0] out_level_q, out_level_d;
  logic [LANES-1:0]       out_bit_q, out_bit_d;
  logic                   out_valid_q;
  logic [15:0]            lfsr_q, lfsr_d;
  mode_e                  mode_sel;

  assign mode_sel = mode_e'(mode);

  // Galois form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0]        target, nxt, shaped;
    logic [WIDTH:0]          lvl_ext, slew_up, slew_dn;
    logic signed [WIDTH:0]   diff, iir_step;
    logic [NOISE_BITS-1:0]   noise;
    logic signed [WIDTH+1:0] noise_ext, noisy;
    logic                    slice_bit;

    assign target  = in[k] ? MAX_LVL : '0;
    assign lvl_ext = {1'b0, level_q[k]};
    assign slew_up = lvl_ext + SLEW_EXT;
    // An underflow below zero shows up as the extra top bit being set.
    assign slew_dn = lvl_ext - SLEW_EXT;
    assign diff    = $signed({1'b0, target}) - $signed(lvl_ext);

    // NOTE: each combinational block assigns its output before any condition, so no latch is inferred.
    always_comb begin
      iir_step = diff >>> ALPHA_SHIFT;
      if (iir_step == '0 && diff != '0) begin
        iir_step = diff[WIDTH] ? '1 : (WIDTH+1)'(1);
      end
    end

    always_comb begin
      nxt = level_q[k];
      case (mode_sel)
        MODE_BYPASS: nxt = target;
        MODE_SLEW: begin
          if (in[k]) nxt = (slew_up > MAX_EXT) ? MAX_LVL : slew_up[WIDTH-1:0];
          else       nxt = slew_dn[WIDTH] ? '0 : slew_dn[WIDTH-1:0];
        end
        MODE_IIR:    nxt = level_q[k] + iir_step[WIDTH-1:0];
        default:     nxt = level_q[k];
      endcase
    end

    assign noise     = lfsr_q[k*NOISE_BITS +: NOISE_BITS];
    assign noise_ext = {{(WIDTH+2-NOISE_BITS){noise[NOISE_BITS-1]}}, noise};
    assign noisy     = $signed({2'b00, nxt}) + noise_ext;

    always_comb begin
      shaped = nxt;
      if (NOISE_EN) begin
        if (noisy[WIDTH+1])  shaped = '0;
        else if (noisy[WIDTH]) shaped = MAX_LVL;
        else                 shaped = noisy[WIDTH-1:0];
      end
    end

    // Inside the hysteresis window the previous decision is kept.
    always_comb begin
      slice_bit = out_bit_q[k];
      if (shaped >= SLICE_HI)     slice_bit = 1'b1;
      else if (shaped < SLICE_LO) slice_bit = 1'b0;
    end

    assign level_d[k]                    = nxt;
    assign out_level_d[k*WIDTH +: WIDTH] = shaped;
    assign out_bit_d[k]                  = slice_bit;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-lane level array is small and must restart from zero, so it is reset explicitly.
      for (int k = 0; k < LANES; k++) level_q[k] <= '0;
      out_level_q <= '0;
      out_bit_q   <= '0;
      out_valid_q <= 1'b0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      out_valid_q <= en;
      if (en) begin
        level_q     <= level_d;
        out_level_q <= out_level_d;
        out_bit_q   <= out_bit_d;
        lfsr_q      <= lfsr_d;
      end
    end
  end

  assign out_level = out_level_q;
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_channel_emulator.sv
// Scoreboard bench for channel_emulator: a plain and a noisy instance share stimulus
// and are checked every cycle against a behavioural model, plus per-scenario checks.
module tb_channel_emulator;

  logic        clk;
  logic        rst, en;
  logic [1:0]  mode;
  logic [3:0]  in;
  logic [31:0] lvl0, lvl1;
  logic [3:0]  bit0, bit1;
  logic        val0, val1;

  int n_cmp = 0;
  int n_bad = 0;

  channel_emulator #(.NOISE_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in),
    .out_level(lvl0), .out_bit(bit0), .out_valid(val0)
  );

  channel_emulator #(.NOISE_EN(1'b1)) dut_n (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in),
    .out_level(lvl1), .out_bit(bit1), .out_valid(val1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] lvl;
    logic [3:0]  bits;
    logic        valid;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t sb[$];

  int          m_lvl [2][4];
  logic [31:0] m_out [2];
  logic [3:0]  m_bit [2];
  logic [15:0] m_lfsr;
  logic        m_valid;

  task automatic model_update(input logic r, input logic e, input logic [1:0] md,
                              input logic [3:0] iv);
    if (r) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) m_lvl[d][k] = 0;
        m_out[d] = '0;
        m_bit[d] = '0;
      end
      m_lfsr  = 16'hACE1;
      m_valid = 1'b0;
    end else begin
      m_valid = e;
      if (e) begin
        for (int d = 0; d < 2; d++) begin
          for (int k = 0; k < 4; k++) begin
            int tgt, lv, df, st, v, o;
            tgt = iv[k] ? 255 : 0;
            lv  = m_lvl[d][k];
            case (md)
              2'd0: lv = tgt;
              2'd1: lv = iv[k] ? ((lv + 1 > 255) ? 255 : lv + 1) : ((lv - 1 < 0) ? 0 : lv - 1);
              2'd2: begin
                df = tgt - lv;
                st = df >>> 3;
                if (st == 0 && df != 0) st = (df > 0) ? 1 : -1;
                lv = lv + st;
              end
              default: ;
            endcase
            m_lvl[d][k] = lv;
            o = lv;
            if (d == 1) begin
              v = int'((m_lfsr >> (2 * k)) & 16'h0003);
              o = lv + ((v >= 2) ? v - 4 : v);
              if (o < 0)   o = 0;
              if (o > 255) o = 255;
            end
            m_out[d][k*8 +: 8] = o[7:0];
            if (o >= 136)     m_bit[d][k] = 1'b1;
            else if (o < 120) m_bit[d][k] = 1'b0;
          end
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
    end
  endtask

  // Drive one clock of stimulus, push the model's prediction, return 2 units after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] md, input logic [3:0] iv);
    exp_t x;
    rst = r; en = e; mode = md; in = iv;
    model_update(r, e, md, iv);
    x.a.lvl = m_out[0]; x.a.bits = m_bit[0]; x.a.valid = m_valid;
    x.b.lvl = m_out[1]; x.b.bits = m_bit[1]; x.b.valid = m_valid;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp += 6;
      if (lvl0 !== e.a.lvl)   begin n_bad++; $display("FAIL sb_level t=%0t got=%h exp=%h", $time, lvl0, e.a.lvl); end
      if (bit0 !== e.a.bits)  begin n_bad++; $display("FAIL sb_bit t=%0t got=%b exp=%b", $time, bit0, e.a.bits); end
      if (val0 !== e.a.valid) begin n_bad++; $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, val0, e.a.valid); end
      if (lvl1 !== e.b.lvl)   begin n_bad++; $display("FAIL sb_noisy_level t=%0t got=%h exp=%h", $time, lvl1, e.b.lvl); end
      if (bit1 !== e.b.bits)  begin n_bad++; $display("FAIL sb_noisy_bit t=%0t got=%b exp=%b", $time, bit1, e.b.bits); end
      if (val1 !== e.b.valid) begin n_bad++; $display("FAIL sb_noisy_valid t=%0t got=%b exp=%b", $time, val1, e.b.valid); end
    end
  end

  task automatic test_reset();
    step(1'b1, 1'b0, 2'd0, 4'h0);
    step(1'b1, 1'b1, 2'd1, 4'hF);
    n_cmp++; if (lvl0 !== 32'h0) begin n_bad++; $display("FAIL reset_level got=%h exp=0", lvl0); end
    n_cmp++; if (bit0 !== 4'h0)  begin n_bad++; $display("FAIL reset_bit got=%b exp=0", bit0); end
    n_cmp++; if (val0 !== 1'b0)  begin n_bad++; $display("FAIL reset_valid got=%b exp=0", val0); end
    n_cmp++; if (lvl1 !== 32'h0) begin n_bad++; $display("FAIL reset_noisy_level got=%h exp=0", lvl1); end
  endtask

  task automatic test_slew_up();
    int rise_at = -1;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 2'd1, 4'hF);
      if (rise_at < 0 && bit0[0] === 1'b1) rise_at = int'(lvl0[7:0]);
      if (i == 0) begin
        n_cmp++; if (lvl0 !== 32'h01010101) begin n_bad++; $display("FAIL slew_first got=%h exp=01010101", lvl0); end
      end
    end
    n_cmp++; if (rise_at !== 136) begin n_bad++; $display("FAIL slew_rise_level got=%0d exp=136", rise_at); end
    n_cmp++; if (lvl0 !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL slew_saturate got=%h exp=ffffffff", lvl0); end
  endtask

  task automatic test_slew_down();
    int fall_at = -1;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 2'd1, 4'h0);
      if (fall_at < 0 && bit0[0] === 1'b0) fall_at = int'(lvl0[7:0]);
      if (i == 0) begin
        n_cmp++; if (lvl0[7:0] !== 8'd254) begin n_bad++; $display("FAIL slew_down_first got=%0d exp=254", lvl0[7:0]); end
      end
    end
    n_cmp++; if (fall_at !== 119) begin n_bad++; $display("FAIL slew_fall_level got=%0d exp=119", fall_at); end
    n_cmp++; if (lvl0 !== 32'h0) begin n_bad++; $display("FAIL slew_floor got=%h exp=0", lvl0); end
  endtask

  task automatic test_bypass();
    logic [3:0]  pat [5] = '{4'hF, 4'h0, 4'hF, 4'h5, 4'hA};
    logic [31:0] lv  [5] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h00FF00FF, 32'hFF00FF00};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'd0, pat[i]);
      n_cmp++; if (lvl0 !== lv[i])  begin n_bad++; $display("FAIL bypass_level[%0d] got=%h exp=%h", i, lvl0, lv[i]); end
      n_cmp++; if (bit0 !== pat[i]) begin n_bad++; $display("FAIL bypass_bit[%0d] got=%b exp=%b", i, bit0, pat[i]); end
      n_cmp++; if (val0 !== 1'b1)   begin n_bad++; $display("FAIL bypass_valid[%0d] got=%b exp=1", i, val0); end
    end
    step(1'b0, 1'b0, 2'd0, 4'h3);
    n_cmp++; if (val0 !== 1'b0) begin n_bad++; $display("FAIL idle_valid got=%b exp=0", val0); end
    n_cmp++; if (lvl0 !== 32'hFF00FF00) begin n_bad++; $display("FAIL idle_level got=%h exp=ff00ff00", lvl0); end
  endtask

  task automatic test_iir();
    logic [7:0] first [3] = '{8'd31, 8'd59, 8'd83};
    step(1'b1, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 2'd2, 4'hF);
      if (i < 3) begin
        n_cmp++; if (lvl0[7:0] !== first[i]) begin n_bad++; $display("FAIL iir_rise[%0d] got=%0d exp=%0d", i, lvl0[7:0], first[i]); end
      end
    end
    n_cmp++; if (lvl0 !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL iir_top got=%h exp=ffffffff", lvl0); end
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 2'd2, 4'h0);
    n_cmp++; if (lvl0 !== 32'h0) begin n_bad++; $display("FAIL iir_bottom got=%h exp=0", lvl0); end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 2'd1, 4'hF);
    for (int i = 0; i < 12; i++) begin
      logic e;
      e = (i % 3 == 0);
      step(1'b0, e, 2'd3, 4'(i));
      n_cmp++; if (lvl0 !== 32'hC8C8C8C8) begin n_bad++; $display("FAIL hold_level[%0d] got=%h exp=c8c8c8c8", i, lvl0); end
      n_cmp++; if (val0 !== e) begin n_bad++; $display("FAIL hold_valid[%0d] got=%b exp=%b", i, val0, e); end
    end
    // Mode and input change on the same edge: slew mode sees the new in=0.
    step(1'b0, 1'b1, 2'd1, 4'h0);
    n_cmp++; if (lvl0 !== 32'hC7C7C7C7) begin n_bad++; $display("FAIL mode_switch got=%h exp=c7c7c7c7", lvl0); end
    step(1'b0, 1'b0, 2'd0, 4'hF);
    n_cmp++; if (lvl0 !== 32'hC7C7C7C7) begin n_bad++; $display("FAIL en_low_hold got=%h exp=c7c7c7c7", lvl0); end
  endtask

  task automatic test_noise_repeat();
    logic [31:0] trace [50];
    step(1'b1, 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 2'd1, 4'hF);
      if (i < 50) trace[i] = m_out[1];
    end
    n_cmp++; if (lvl0 !== 32'hC8C8C8C8) begin n_bad++; $display("FAIL noise_prelevel got=%h exp=c8c8c8c8", lvl0); end
    step(1'b1, 1'b1, 2'd1, 4'hF);
    n_cmp++; if (lvl1 !== 32'h0) begin n_bad++; $display("FAIL noise_rst_level got=%h exp=0", lvl1); end
    n_cmp++; if (bit1 !== 4'h0)  begin n_bad++; $display("FAIL noise_rst_bit got=%b exp=0", bit1); end
    n_cmp++; if (val1 !== 1'b0)  begin n_bad++; $display("FAIL noise_rst_valid got=%b exp=0", val1); end
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 2'd1, 4'hF);
      n_cmp++; if (lvl1 !== trace[i]) begin n_bad++; $display("FAIL noise_repeat[%0d] got=%h exp=%h", i, lvl1, trace[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; in = 4'h0;
    #2;
    test_reset();
    test_slew_up();
    test_slew_down();
    test_bypass();
    test_iir();
    test_hold();
    test_noise_repeat();
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
